// File: rtl/ring_sequence_checker.sv
// Receive-side monitor for a one-hot rotating ring word: checks each qualified sample is the
// previous one rotated left by one, reports the hot-bit index, lock status and a saturating error count.
module ring_sequence_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         din,
  input  logic                     din_en,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic                     pos_valid,
  output logic                     locked,
  output logic                     err_pulse,
  output logic [ERR_W-1:0]         err_cnt
);

  localparam int POS_W = $clog2(WIDTH);
  localparam int GC_W  = $clog2(LOCK_CNT + 1);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  function automatic logic is_one_hot(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] low_clear;
    // Clearing the lowest set bit leaves zero only for power-of-two words.
    low_clear = x & (x - {{(WIDTH-1){1'b0}}, 1'b1});
    return (x != {WIDTH{1'b0}}) && (low_clear == {WIDTH{1'b0}});
  endfunction

  function automatic logic [POS_W-1:0] hot_index(input logic [WIDTH-1:0] x);
    logic [POS_W-1:0] idx;
    idx = {POS_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (x[i]) begin
        idx = idx | POS_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [1:0]       state_q,     state_d;
  logic [WIDTH-1:0] prev_q,      prev_d;
  logic [GC_W-1:0]  good_cnt_q,  good_cnt_d;
  logic [POS_W-1:0] pos_q,       pos_d;
  logic             pos_valid_q, pos_valid_d;
  logic             locked_q,    locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_cnt_q,   err_cnt_d;

  logic [WIDTH-1:0] exp_word;
  logic             din_one_hot;
  logic             din_is_exp;
  logic [GC_W-1:0]  good_cnt_inc;
  logic [ERR_W-1:0] err_cnt_inc;

  assign exp_word     = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
  assign din_one_hot  = is_one_hot(din);
  assign din_is_exp   = (din == exp_word);
  assign good_cnt_inc = good_cnt_q + {{(GC_W-1){1'b0}}, 1'b1};
  assign err_cnt_inc  = (err_cnt_q == {ERR_W{1'b1}}) ? err_cnt_q
                                                     : err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};

  // Next-state and next-output computation for the hunt/check/locked sequencer.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    good_cnt_d  = good_cnt_q;
    pos_d       = pos_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    if (din_en) begin
      case (state_q)
        ST_HUNT: begin
          if (din_one_hot) begin
            prev_d     = din;
            good_cnt_d = {GC_W{1'b0}};
            state_d    = ST_CHECK;
          end else begin
            state_d    = ST_HUNT;
          end
        end
        ST_CHECK: begin
          if (din_is_exp) begin
            prev_d     = din;
            good_cnt_d = good_cnt_inc;
            if (good_cnt_inc == GC_W'(LOCK_CNT)) begin
              state_d = ST_LOCKED;
              pos_d   = hot_index(din);
            end else begin
              state_d = ST_CHECK;
            end
          end else if (din_one_hot) begin
            prev_d     = din;
            good_cnt_d = {GC_W{1'b0}};
            state_d    = ST_CHECK;
          end else begin
            state_d    = ST_HUNT;
          end
        end
        ST_LOCKED: begin
          if (din_is_exp) begin
            prev_d = din;
            pos_d  = hot_index(din);
          end else begin
            err_pulse_d = 1'b1;
            err_cnt_d   = err_cnt_inc;
            // A clean one-hot mismatch already gives a fresh reference, so skip hunting.
            if (din_one_hot) begin
              prev_d     = din;
              good_cnt_d = {GC_W{1'b0}};
              state_d    = ST_CHECK;
            end else begin
              state_d    = ST_HUNT;
            end
          end
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    locked_d    = (state_d == ST_LOCKED);
    pos_valid_d = (state_d == ST_LOCKED);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      prev_q      <= {WIDTH{1'b0}};
      good_cnt_q  <= {GC_W{1'b0}};
      pos_q       <= {POS_W{1'b0}};
      pos_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= {ERR_W{1'b0}};
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      good_cnt_q  <= good_cnt_d;
      pos_q       <= pos_d;
      pos_valid_q <= pos_valid_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign pos       = pos_q;
  assign pos_valid = pos_valid_q;
  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ring_sequence_checker.sv
// Directed bench for ring_sequence_checker: a behavioural model pushes expected outputs into a
// scoreboard queue as each sample is driven; they are popped and asserted one cycle later.
module tb_ring_sequence_checker;

  logic       clk;
  logic       rst;
  logic [3:0] din;
  logic       din_en;
  logic [1:0] pos;
  logic       pos_valid;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0] pos;
    logic       lk;
    logic       ep;
    logic [7:0] ec;
  } exp_t;

  exp_t sb[$];

  int         m_state;
  logic [3:0] m_prev;
  int         m_good;
  logic [1:0] m_pos;
  logic       m_ep;
  int         m_err;
  logic [3:0] ring;

  ring_sequence_checker #(.WIDTH(4), .LOCK_CNT(2), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .din(din), .din_en(din_en), .pos(pos),
    .pos_valid(pos_valid), .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] rol(input logic [3:0] x);
    return {x[2:0], x[3]};
  endfunction

  function automatic logic [1:0] idx_of(input logic [3:0] x);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (x[i]) r = 2'(i);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_step(input logic [3:0] d, input logic en);
    m_ep = 1'b0;
    if (en) begin
      if (m_state == 0) begin
        if ($countones(d) == 1) begin m_prev = d; m_good = 0; m_state = 1; end
      end else if (m_state == 1) begin
        if (d == rol(m_prev)) begin
          m_prev = d; m_good = m_good + 1;
          if (m_good == 2) begin m_state = 2; m_pos = idx_of(d); end
        end else if ($countones(d) == 1) begin
          m_prev = d; m_good = 0;
        end else begin
          m_state = 0;
        end
      end else begin
        if (d == rol(m_prev)) begin
          m_prev = d; m_pos = idx_of(d);
        end else begin
          m_ep = 1'b1;
          if (m_err < 255) m_err = m_err + 1;
          if ($countones(d) == 1) begin m_prev = d; m_good = 0; m_state = 1; end
          else m_state = 0;
        end
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.pos = m_pos;
    e.lk  = (m_state == 2);
    e.ep  = m_ep;
    e.ec  = 8'(m_err);
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, ".pos"}, 32'(pos), 32'(e.pos));
      chk({tag, ".locked"}, 32'(locked), 32'(e.lk));
      chk({tag, ".pos_valid"}, 32'(pos_valid), 32'(e.lk));
      chk({tag, ".err_pulse"}, 32'(err_pulse), 32'(e.ep));
      chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(e.ec));
    end
  endtask

  task automatic step(input string tag, input logic [3:0] d, input logic en);
    din    = d;
    din_en = en;
    model_step(d, en);
    push_exp();
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  task automatic do_reset(input string tag);
    rst    = 1'b1;
    din    = 4'b1000;
    din_en = 1'b1;
    m_state = 0; m_prev = 4'd0; m_good = 0; m_pos = 2'd0; m_ep = 1'b0; m_err = 0;
    push_exp();
    @(posedge clk);
    #1;
    pop_check(tag);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; din = 4'd0; din_en = 1'b0;
    m_state = 0; m_prev = 4'd0; m_good = 0; m_pos = 2'd0; m_ep = 1'b0; m_err = 0;

    do_reset("reset");
    chk("reset.locked", 32'(locked), 32'd0);
    chk("reset.err_cnt", 32'(err_cnt), 32'd0);

    // T1: lock after three samples, then wrap MSB -> bit0
    step("T1.s0", 4'b0001, 1'b1);
    chk("T1.not_locked_yet", 32'(locked), 32'd0);
    step("T1.s1", 4'b0010, 1'b1);
    chk("T1.still_unlocked", 32'(locked), 32'd0);
    step("T1.s2", 4'b0100, 1'b1);
    chk("T1.locked", 32'(locked), 32'd1);
    chk("T1.pos2", 32'(pos), 32'd2);
    step("T1.s3", 4'b1000, 1'b1);
    chk("T1.pos3", 32'(pos), 32'd3);
    step("T1.s4", 4'b0001, 1'b1);
    chk("T1.pos_wrap", 32'(pos), 32'd0);

    // T2: one-hot mismatch in LOCKED, pulse clears on a gap, relock via CHECK
    step("T2.bad", 4'b0100, 1'b1);
    chk("T2.err_pulse", 32'(err_pulse), 32'd1);
    chk("T2.err_cnt", 32'(err_cnt), 32'd1);
    chk("T2.unlocked", 32'(locked), 32'd0);
    chk("T2.pos_held", 32'(pos), 32'd0);
    step("T2.gap", 4'b1111, 1'b0);
    chk("T2.pulse_gone", 32'(err_pulse), 32'd0);
    step("T2.r1", 4'b1000, 1'b1);
    step("T2.r2", 4'b0001, 1'b1);
    chk("T2.relocked", 32'(locked), 32'd1);
    chk("T2.relock_pos", 32'(pos), 32'd0);

    // non-one-hot mismatch in LOCKED drops to HUNT
    step("NH.bad", 4'b0110, 1'b1);
    chk("NH.err_cnt", 32'(err_cnt), 32'd2);
    step("NH.bad2", 4'b0000, 1'b1);
    chk("NH.no_pulse_in_hunt", 32'(err_pulse), 32'd0);

    // T3: garbage in HUNT after reset
    do_reset("T3.rst");
    step("T3.g0", 4'b0000, 1'b1);
    step("T3.g1", 4'b0011, 1'b1);
    step("T3.g2", 4'b1111, 1'b1);
    chk("T3.err_cnt", 32'(err_cnt), 32'd0);
    chk("T3.locked", 32'(locked), 32'd0);

    // resync in CHECK: wrong one-hot restarts the count with no error
    step("RS.s0", 4'b0001, 1'b1);
    step("RS.s1", 4'b0010, 1'b1);
    step("RS.jump", 4'b1000, 1'b1);
    chk("RS.no_err", 32'(err_pulse), 32'd0);
    step("RS.s2", 4'b0001, 1'b1);
    chk("RS.not_locked", 32'(locked), 32'd0);
    step("RS.s3", 4'b0010, 1'b1);
    chk("RS.locked", 32'(locked), 32'd1);
    chk("RS.pos1", 32'(pos), 32'd1);

    // T4: qualifier gaps with junk on din
    do_reset("T4.rst");
    step("T4.s0", 4'b0001, 1'b1);
    step("T4.g0", 4'b1010, 1'b0);
    step("T4.s1", 4'b0010, 1'b1);
    step("T4.g1", 4'b1111, 1'b0);
    step("T4.g2", 4'b0000, 1'b0);
    step("T4.s2", 4'b0100, 1'b1);
    chk("T4.locked", 32'(locked), 32'd1);
    chk("T4.pos2", 32'(pos), 32'd2);
    step("T4.g3", 4'b0011, 1'b0);
    chk("T4.gap_no_err", 32'(err_pulse), 32'd0);
    step("T4.s3", 4'b1000, 1'b1);
    step("T4.g4", 4'b0000, 1'b0);
    step("T4.s4", 4'b0001, 1'b1);
    chk("T4.pos_wrap", 32'(pos), 32'd0);
    chk("T4.err_cnt", 32'(err_cnt), 32'd0);

    // T5: 300 LOCKED mismatches, relocking after each
    ring = 4'b0001;
    for (int k = 0; k < 300; k++) begin
      ring = rol(rol(ring));
      step("T5.bad", ring, 1'b1);
      ring = rol(ring);
      step("T5.r1", ring, 1'b1);
      ring = rol(ring);
      step("T5.r2", ring, 1'b1);
    end
    chk("T5.err_sat", 32'(err_cnt), 32'd255);
    chk("T5.locked", 32'(locked), 32'd1);
    ring = rol(rol(ring));
    step("T5.extra", ring, 1'b1);
    chk("T5.err_stays", 32'(err_cnt), 32'd255);
    chk("T5.extra_pulse", 32'(err_pulse), 32'd1);
    ring = rol(ring);
    step("T5.x1", ring, 1'b1);
    ring = rol(ring);
    step("T5.x2", ring, 1'b1);

    // T6: reset while locked at pos 3, then relock from scratch
    while (ring != 4'b1000) begin
      ring = rol(ring);
      step("T6.spin", ring, 1'b1);
    end
    chk("T6.pre_pos3", 32'(pos), 32'd3);
    do_reset("T6.rst");
    chk("T6.pos0", 32'(pos), 32'd0);
    chk("T6.locked0", 32'(locked), 32'd0);
    chk("T6.err0", 32'(err_cnt), 32'd0);
    step("T6.s0", 4'b0001, 1'b1);
    step("T6.s1", 4'b0010, 1'b1);
    chk("T6.not_yet", 32'(locked), 32'd0);
    step("T6.s2", 4'b0100, 1'b1);
    chk("T6.relocked", 32'(locked), 32'd1);
    chk("T6.pos2", 32'(pos), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
